// File: rtl/npu_pkg.sv
// Shared NPU host-loader definitions: bus width, loader FSM states and the
// order of the configuration words at the head of every send stream.
package npu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGap,
        StWait,
        StRecv,
        StDrain,
        StErr
    } state_e;

    // Word index of each configuration field within the send stream
    localparam int unsigned CFG_NUM_LAYERS = 0;
    localparam int unsigned CFG_NUM_IN     = 1;
    localparam int unsigned CFG_NUM_H1     = 2;
    localparam int unsigned CFG_NUM_H2     = 3;
    localparam int unsigned CFG_NUM_OUT    = 4;
    localparam int unsigned CFG_ACT        = 5;
    localparam int unsigned CFG_WORDS      = 6;

endpackage

// File: rtl/npu_res_fifo.sv
// Two-entry result FIFO; rdata is the head entry and holds while not popped.
module npu_res_fifo #(
    parameter int unsigned DATA_W = npu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign valid   = (count_q != 2'd0);
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/npu_host_loader.sv
// Host-side NPU job sequencer: streams send words onto the NPU bus, waits for
// the NPU result flag, then reads result words into a small result FIFO.
module npu_host_loader #(
    parameter int unsigned DATA_W  = npu_pkg::DATA_W,
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned OUT_W   = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  send_len,
    input  logic [OUT_W-1:0]  recv_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              npu_we,
    output logic              npu_oe,
    output logic [DATA_W-1:0] npu_data_o,
    output logic              npu_data_oe,
    input  logic [DATA_W-1:0] npu_data_i,
    input  logic              npu_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import npu_pkg::*;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   send_len_q, send_cnt_q;
    logic [OUT_W-1:0]   recv_len_q, rd_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic               err_q;
    logic               rd_pend_q;
    logic               accept;
    logic               issue;
    logic               pop;
    logic [1:0]         fifo_count;
    logic [2:0]         credit;

    assign src_ready = (state_q == StSend);
    assign accept    = src_valid && src_ready;
    assign pop       = res_valid && res_ready;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

    // Occupancy after this edge plus the read whose data lands next cycle
    assign credit = {1'b0, fifo_count} + {2'b0, rd_pend_q} + {2'b0, npu_oe} - {2'b0, pop};
    assign issue  = (state_q == StRecv) && (credit < 3'd2);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (send_len == '0) ? StGap : StSend;
            end
            StSend: begin
                if (accept && (send_cnt_q == send_len_q - LEN_W'(1))) state_d = StGap;
            end
            StGap: state_d = StWait;
            StWait: begin
                if (npu_ready) begin
                    state_d = (recv_len_q == '0) ? StDrain : StRecv;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end
            end
            StRecv: begin
                if (issue && (rd_cnt_q == recv_len_q - OUT_W'(1))) state_d = StDrain;
            end
            StDrain: begin
                if ((fifo_count == 2'd0) && !npu_oe && !rd_pend_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StErr: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            send_len_q  <= '0;
            recv_len_q  <= '0;
            send_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            npu_we      <= 1'b0;
            npu_oe      <= 1'b0;
            npu_data_oe <= 1'b0;
            npu_data_o  <= '0;
        end else begin
            state_q     <= state_d;
            npu_we      <= accept;
            npu_oe      <= issue;
            npu_data_oe <= (state_q == StSend);
            rd_pend_q   <= npu_oe;
            if (accept) npu_data_o <= src_data;
            if ((state_q == StIdle) && start) begin
                send_len_q <= send_len;
                recv_len_q <= recv_len;
                err_q      <= 1'b0;
            end
            if (state_d == StErr) err_q <= 1'b1;
            send_cnt_q <= (state_q == StSend) ? send_cnt_q + LEN_W'(accept) : '0;
            rd_cnt_q   <= (state_q == StRecv) ? rd_cnt_q + OUT_W'(issue) : '0;
            wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + WAIT_W'(1) : '0;
        end
    end

    npu_res_fifo #(
        .DATA_W (DATA_W)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend_q),
        .wdata (npu_data_i),
        .pop   (pop),
        .rdata (res_data),
        .valid (res_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_npu_host_loader.sv
// Directed bench for npu_host_loader with a simple NPU and word-source model.
module tb_npu_host_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 12;
    localparam int unsigned OW = 5;
    localparam int unsigned TO = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] send_len;
    logic [OW-1:0] recv_len;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] src_data;
    logic          npu_we;
    logic          npu_oe;
    logic [DW-1:0] npu_data_o;
    logic          npu_data_oe;
    logic [DW-1:0] npu_data_i = '0;
    logic          npu_ready  = 1'b0;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] src_words [16];
    logic [DW-1:0] out_words [8];
    int            src_n   = 0;
    int            src_idx = 0;
    int            src_cyc = 0;
    logic          src_en  = 1'b0;
    logic          bub_en  = 1'b0;
    logic          model_en = 1'b1;
    int            ready_cnt = 0;
    int            out_idx   = 0;
    logic [DW-1:0] wr_q [$];
    logic [DW-1:0] rd_q [$];
    int            oe_cnt   = 0;
    int            done_cnt = 0;
    logic          inv_bad  = 1'b0;

    npu_host_loader #(
        .DATA_W  (DW),
        .LEN_W   (LW),
        .OUT_W   (OW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .send_len    (send_len),
        .recv_len    (recv_len),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .npu_we      (npu_we),
        .npu_oe      (npu_oe),
        .npu_data_o  (npu_data_o),
        .npu_data_oe (npu_data_oe),
        .npu_data_i  (npu_data_i),
        .npu_ready   (npu_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word source; bubble cycles are counted from the first SEND cycle
    assign src_data  = src_words[src_idx[3:0]];
    assign src_valid = src_en && (src_idx < src_n) && !(bub_en && (src_cyc == 3 || src_cyc == 5));

    always @(posedge clk) begin
        if (!src_en) src_idx <= 0;
        else if (src_valid && src_ready) src_idx <= src_idx + 1;
        if (!src_ready) src_cyc <= 0;
        else src_cyc <= src_cyc + 1;
    end

    // NPU: ready 15 cycles after the last write, read data one cycle after oe
    always @(posedge clk) begin
        if (rst || start) begin
            ready_cnt  <= 0;
            npu_ready  <= 1'b0;
            out_idx    <= 0;
            npu_data_i <= '0;
        end else begin
            if (npu_we) ready_cnt <= 15;
            else if (ready_cnt != 0) ready_cnt <= ready_cnt - 1;
            if (model_en && !npu_we && ready_cnt == 1) npu_ready <= 1'b1;
            if (npu_oe) begin
                npu_data_i <= out_words[out_idx[2:0]];
                out_idx    <= out_idx + 1;
            end
        end
    end

    // Bus monitor: written words, delivered results, oe/done counts, bus overlap
    always @(posedge clk) begin
        if (start) begin
            wr_q.delete();
            rd_q.delete();
            oe_cnt   = 0;
            done_cnt = 0;
        end else begin
            if (npu_we) wr_q.push_back(npu_data_o);
            if (res_valid && res_ready) rd_q.push_back(res_data);
            if (npu_oe) oe_cnt++;
            if (done) done_cnt++;
        end
        if ((npu_we && npu_oe) || (npu_data_oe && npu_oe)) begin
            if (!inv_bad)
                $display("FAIL bus_invariant: we=%0b oe=%0b data_oe=%0b, required no overlap",
                         npu_we, npu_oe, npu_data_oe);
            inv_bad = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        if (i < rd_q.size()) return rd_q[i];
        return 'x;
    endfunction

    task automatic idle(input int n);
        src_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first busy cycle
    task automatic start_job(input int sl, input int rl);
        src_en   = 1'b1;
        send_len = LW'(sl);
        recv_len = OW'(rl);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic set_basic();
        for (int k = 0; k < 6; k++) src_words[k] = '0;
        src_words[6] = 32'h4000_0000;
        src_words[7] = 32'h4580_0000;
        src_words[8] = 32'h4480_0000;
        src_n = 9;
    endtask

    initial begin
        int            cyc;
        int            n_oe;
        logic [10:0]   pat;

        rst = 1'b1; start = 1'b0; send_len = '0; recv_len = '0; res_ready = 1'b1;
        for (int k = 0; k < 16; k++) src_words[k] = '0;
        for (int k = 0; k < 8; k++) out_words[k] = '0;
        repeat (3) @(negedge clk);
        chk1("rst_we", npu_we, 1'b0);
        chk1("rst_oe", npu_oe, 1'b0);
        chk1("rst_data_oe", npu_data_oe, 1'b0);
        chk("rst_data_o", npu_data_o, 32'h0);
        chk1("rst_src_ready", src_ready, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0;
        idle(2);

        // Basic job: 9 back-to-back writes, one gap, one read
        set_basic();
        out_words[0] = 32'h45C0_0000;
        start_job(9, 1);
        chk1("basic_we_first", npu_we, 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk1("basic_we", npu_we, 1'b1);
            chk1("basic_data_oe", npu_data_oe, 1'b1);
            chk("basic_data", npu_data_o, src_words[k]);
        end
        @(negedge clk);
        chk1("basic_gap_we", npu_we, 1'b0);
        chk1("basic_gap_data_oe", npu_data_oe, 1'b0);
        wait_done(200, cyc);
        chk1("basic_done", done, 1'b1);
        @(negedge clk);
        chk("basic_oe_cnt", oe_cnt, 32'd1);
        chk("basic_done_cnt", done_cnt, 32'd1);
        chk("basic_res_cnt", rd_q.size(), 32'd1);
        chk("basic_res_data", rd_at(0), 32'h45C0_0000);
        chk1("basic_idle", busy, 1'b0);

        // Source bubbles on SEND cycles 3 and 5
        idle(2);
        for (int k = 0; k < 9; k++) src_words[k] = 32'hA000_0000 | (k + 1);
        src_n = 9;
        bub_en = 1'b1;
        out_words[0] = 32'h1234_5678;
        pat = 11'b11111010111;
        start_job(9, 1);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk1("bub_we", npu_we, pat[i]);
            chk1("bub_data_oe", npu_data_oe, 1'b1);
        end
        @(negedge clk);
        chk1("bub_gap_we", npu_we, 1'b0);
        chk1("bub_gap_data_oe", npu_data_oe, 1'b0);
        wait_done(200, cyc);
        chk1("bub_done", done, 1'b1);
        @(negedge clk);
        chk("bub_wr_cnt", wr_q.size(), 32'd9);
        for (int k = 0; k < 9; k++) chk("bub_wr_word", wr_at(k), src_words[k]);
        bub_en = 1'b0;

        // Result backpressure: 4 reads, res_ready low for 6 cycles
        idle(2);
        src_words[0] = 32'h0000_00AA;
        src_words[1] = 32'h0000_00BB;
        src_n = 2;
        for (int k = 0; k < 4; k++) out_words[k] = 32'hC0DE_0001 + k;
        res_ready = 1'b0;
        start_job(2, 4);
        cyc = 0;
        while (npu_oe !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk1("bp_first_oe", npu_oe, 1'b1);
        n_oe = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (npu_oe) n_oe++;
        end
        chk("bp_oe_stall", n_oe, 32'd2);
        chk1("bp_res_valid", res_valid, 1'b1);
        chk("bp_res_head", res_data, 32'hC0DE_0001);
        res_ready = 1'b1;
        wait_done(200, cyc);
        chk1("bp_done", done, 1'b1);
        @(negedge clk);
        chk("bp_oe_cnt", oe_cnt, 32'd4);
        chk("bp_res_cnt", rd_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) chk("bp_res_word", rd_at(k), out_words[k]);
        chk("bp_done_cnt", done_cnt, 32'd1);

        // Timeout: 1 send cycle, 1 gap cycle, TO wait cycles, then ERR
        idle(2);
        model_en = 1'b0;
        src_words[0] = 32'h0BAD_0001;
        src_n = 1;
        start_job(1, 1);
        wait_done(200, cyc);
        chk("to_cycles", cyc, 32'(3 + TO));
        chk1("to_done", done, 1'b1);
        chk1("to_err", err, 1'b1);
        @(negedge clk);
        chk1("to_done_low", done, 1'b0);
        chk1("to_err_hold", err, 1'b1);
        chk1("to_idle", busy, 1'b0);
        chk("to_done_cnt", done_cnt, 32'd1);
        model_en = 1'b1;
        out_words[0] = 32'h600D_0001;
        idle(2);
        chk1("to_err_sticky", err, 1'b1);
        start_job(1, 1);
        chk1("to_err_clear", err, 1'b0);
        wait_done(200, cyc);
        chk1("to_next_done", done, 1'b1);
        @(negedge clk);
        chk("to_next_res", rd_at(0), 32'h600D_0001);
        chk1("to_next_err", err, 1'b0);

        // Reset after 4 words of SEND, then a normal job
        idle(2);
        set_basic();
        out_words[0] = 32'h45C0_0000;
        start_job(9, 1);
        repeat (4) @(negedge clk);
        chk1("rj_we_before", npu_we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rj_we", npu_we, 1'b0);
        chk1("rj_data_oe", npu_data_oe, 1'b0);
        chk1("rj_busy", busy, 1'b0);
        chk1("rj_src_ready", src_ready, 1'b0);
        idle(3);
        chk("rj_no_done", done_cnt, 32'd0);
        start_job(9, 1);
        wait_done(200, cyc);
        chk1("rj_next_done", done, 1'b1);
        @(negedge clk);
        chk("rj_next_wr_cnt", wr_q.size(), 32'd9);
        chk("rj_next_res", rd_at(0), 32'h45C0_0000);
        chk("rj_next_done_cnt", done_cnt, 32'd1);

        chk1("bus_invariant", inv_bad, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_host_loader.md
NPU_HOST_LOADER -- requirements
Module: npu_host_loader

Interface
REQ-001 Parameter DATA_W, default 32: NPU bus word width.
REQ-002 Parameter LEN_W, default 12: width of the send-length field.
REQ-003 Parameter OUT_W, default 5: width of the receive-length field.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles to wait for npu_ready.
REQ-005 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: one-cycle pulse that launches a job.
REQ-008 Port send_len, input, LEN_W: count of words to write (config, weights/biases, inputs); latched on start.
REQ-009 Port recv_len, input, OUT_W: count of output words to read; latched on start.
REQ-010 Port src_valid / src_ready / src_data, in / out / in, 1 / 1 / DATA_W: word source stream; a transfer occurs when valid and ready are both high.
REQ-011 Port npu_we / npu_oe, output, 1 each: NPU write enable and output enable.
REQ-012 Port npu_data_o / npu_data_oe, output, DATA_W / 1: bus drive value and tri-state enable; the top level builds the bidirectional bus from these.
REQ-013 Port npu_data_i / npu_ready, input, DATA_W / 1: bus read value and NPU result-ready flag.
REQ-014 Port res_valid / res_ready / res_data, out / in / out, 1 / 1 / DATA_W: result stream.
REQ-015 Port busy / done / err, output, 1 each: busy = state not IDLE; done = one-cycle job-end pulse; err = timeout flag.

Function
REQ-016 The state machine has states IDLE, SEND, GAP, WAIT, RECV, DRAIN and ERR.
REQ-017 IDLE: start latches both lengths and goes to SEND; start in any other state is ignored.
REQ-018 SEND: src_ready is high until send_len words have been accepted; each accepted word appears on npu_data_o with npu_we=1 and npu_data_oe=1 exactly one cycle later.
REQ-019 A cycle with no src transfer produces npu_we=0 the following cycle (a bubble); the bus stays driven throughout SEND.
REQ-020 After the last write cycle, GAP lasts one cycle with npu_we=0 and npu_data_oe=0, then the block enters WAIT.
REQ-021 send_len=0 skips SEND and goes directly to GAP.
REQ-022 WAIT: a wait counter clears on entry; npu_ready=1 goes to RECV, or to DRAIN if recv_len=0.
REQ-023 WAIT: when the counter reaches TIMEOUT with npu_ready still low, the block enters ERR.
REQ-024 RECV: npu_oe is high one cycle per requested word; npu_data_i is valid exactly 1 cycle after npu_oe and is captured into a 2-entry result FIFO.
REQ-025 RECV: npu_oe is issued only when (FIFO occupancy + reads in flight) < 2, so reads run back-to-back while res_ready stays high.
REQ-026 RECV: after recv_len reads are issued, the block enters DRAIN.
REQ-027 DRAIN: when the FIFO is empty and no read is in flight, done pulses for 1 cycle and the block returns to IDLE.
REQ-028 A result FIFO push and pop in the same cycle leaves occupancy unchanged; res_data is the FIFO head and stays stable while res_valid=1 and res_ready=0.
REQ-029 ERR: err=1 and done=1 for one cycle, then IDLE; err stays set until the next accepted start.
REQ-030 npu_we and npu_oe are never high in the same cycle, and npu_data_oe=0 whenever npu_oe=1.
REQ-031 Every bus-side output (npu_we, npu_oe, npu_data_o, npu_data_oe) is registered.

Reset
REQ-032 On rst=1 at a clock edge, the block goes to IDLE, and in that same cycle all of the following are 0: npu_we, npu_oe, npu_data_oe, npu_data_o, src_ready, res_valid, busy, done, err, the FIFO, all counters and the latched lengths.
REQ-033 A reset asserted mid-job abandons the job, releases the bus the following cycle, and does not pulse done.

Structure
REQ-034 A shared package npu_pkg holds the state enumeration, DATA_W, and the NPU config word order (NUM_LAYERS, NUM_IN, NUM_H1, NUM_H2, NUM_OUT, ACT).
REQ-035 The result FIFO is one sub-module, npu_res_fifo (2 entries, DATA_W wide); everything else is inline.

Verification
REQ-036 Basic job: send_len=9, recv_len=1, words 0,0,0,0,0,0,0x40000000,0x45800000,0x44800000 with src_valid held high; NPU model raises ready 15 cycles after its last write -> 9 consecutive npu_we cycles, one GAP cycle, one npu_oe, res_data=0x45C00000, then done.
REQ-037 Source bubbles: src_valid low on cycles 3 and 5 -> npu_we drops on exactly those 2 shifted cycles; NPU receives the same 9 words in order.
REQ-038 Backpressure: recv_len=4 with res_ready low for 6 cycles -> at most 2 oe cycles issued before stalling; all 4 words delivered in order; no loss and no duplicates.
REQ-039 Timeout: npu_ready never asserted -> ERR entered after TIMEOUT cycles in WAIT; err=1 and done pulses once; next start clears err.
REQ-040 Reset in SEND after 4 words -> next cycle npu_we=0, npu_data_oe=0, busy=0; a following job completes normally.
REQ-041 Bus invariant, checked by assertion in all scenarios: npu_we and npu_oe never both high, and npu_data_oe is never high while npu_oe is high.
